pc_unit: RTL

- Parametrised fetch program counter for the pipelined MIPS core.
- Holds the fetch address and selects the next value each cycle: sequential increment, branch/jump redirect, exception vector or ERET return.
- Buffers one redirect that arrives during a stall and releases it when fetch resumes.
- Interrupt/exception entry overrides a stall; all outputs feed IF-stage instruction memory and CP0.

---
 rtl/pc_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Fetch program counter: sequential increment, redirect, exception vector and ERET return,
// with a one-entry redirect buffer for stalls. Define PC_ADDR_CHECK_EN to enable adel checking.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h00003000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'h00004180,
    parameter int unsigned      INC       = 4
`ifdef PC_ADDR_CHECK_EN
    ,
    parameter logic [WIDTH-1:0] TEXT_HI   = 32'h00006FFC
`endif
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             en,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             int_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc_in,
    output logic [WIDTH-1:0] pc_addr,
    output logic [WIDTH-1:0] pc_plus,
    output logic             redir_pend,
    output logic             exc_taken,
    output logic             adel
);

    typedef enum logic {StRun, StPend} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             exc_q, exc_d;
    logic             load;

    assign pc_plus = pc_q + WIDTH'(INC);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        exc_d   = 1'b0;
        load    = 1'b0;
        if (int_req) begin
            pc_d    = EXC_VEC;
            state_d = StRun;
            exc_d   = 1'b1;
        end else if (eret) begin
            pc_d    = epc_in;
            state_d = StRun;
            load    = 1'b1;
        end else if (!en) begin
            // Newest stalled redirect replaces any older buffered one.
            if (redir_valid) begin
                pend_d  = redir_target;
                state_d = StPend;
            end
        end else if (redir_valid) begin
            pc_d    = redir_target;
            state_d = StRun;
            load    = 1'b1;
        end else if (state_q == StPend) begin
            pc_d    = pend_q;
            state_d = StRun;
            load    = 1'b1;
        end else begin
            pc_d = pc_plus;
            load = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StRun;
            pc_q    <= RESET_VEC;
            pend_q  <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            exc_q   <= exc_d;
        end
    end

    assign pc_addr    = pc_q;
    assign redir_pend = (state_q == StPend);
    assign exc_taken  = exc_q;

`ifdef PC_ADDR_CHECK_EN
    logic adel_q, adel_d;

    // Vector load is always legal; a stall leaves the flag paired with the held pc.
    always_comb begin
        adel_d = adel_q;
        if (int_req) begin
            adel_d = 1'b0;
        end else if (load) begin
            adel_d = (pc_d[1:0] != 2'b00) || (pc_d < RESET_VEC) || (pc_d > TEXT_HI);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            adel_q <= 1'b0;
        end else begin
            adel_q <= adel_d;
        end
    end

    assign adel = adel_q;
`else
    logic unused_load;
    assign unused_load = load;
    assign adel        = 1'b0;
`endif

endmodule
